// File: rtl/rv32_pipelined_mul_unit_pkg.sv
// Shared RV32 types for the pipelined multiply unit.
// Op encodings, default depth, fx scale types and partial-product helpers.
package rv32_types;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  localparam int MUL_UNIT_STAGES  = 2;
  localparam int FX_SCALE_ENTRIES = 8;

  typedef logic [4:0] fx_scale_t;

  typedef struct packed {
    logic [33:0] ll;
    logic [33:0] lh;
    logic [33:0] hl;
    logic [33:0] hh;
  } pp_t;

  typedef struct packed {
    mul_op_t     op;
    logic        fx;
    fx_scale_t   sh;
    logic [31:0] add;
  } ctl_t;

  // Each partial product is a signed 34-bit value; weights 2^0, 2^16, 2^32
  function automatic logic [65:0] pp_sum(pp_t pp);
    logic [65:0] s;
    s = {{32{pp.ll[33]}}, pp.ll};
    s = s + ({{32{pp.lh[33]}}, pp.lh} << 16);
    s = s + ({{32{pp.hl[33]}}, pp.hl} << 16);
    s = s + ({{32{pp.hh[33]}}, pp.hh} << 32);
    return s;
  endfunction

endpackage

// File: rtl/rv32_pipelined_mul_unit_if.sv
// Request/response handshake bundle for the pipelined multiply unit.
// slave = unit side, master = issuing/consuming side.
interface rv32_pipelined_mul_unit_if #(
  parameter int TAG_W = 5
) ();
  import rv32_types::*;

  logic             in_valid;
  logic             in_ready;
  mul_op_t          in_op;
  logic             in_fx;
  logic [2:0]       in_scale;
  logic [31:0]      in_op1;
  logic [31:0]      in_op2;
  logic [31:0]      in_add;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_op, in_fx, in_scale,
    input  in_op1, in_op2, in_add, in_tag,
    input  out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

  modport master (
    output in_valid, in_op, in_fx, in_scale,
    output in_op1, in_op2, in_add, in_tag,
    output out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

endinterface

// File: rtl/rv32_mul_pp_stage.sv
// Stage 1: splits two 33-bit operands into 17-bit halves and
// registers the four signed 17x17 partial products.
module rv32_mul_pp_stage
  import rv32_types::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [32:0] a,
  input  logic [32:0] b,
  output pp_t         pp
);

  logic signed [33:0] a_lo, a_hi;
  logic signed [33:0] b_lo, b_hi;
  pp_t pp_d;

  always_comb begin
    a_lo    = {18'b0, a[15:0]};
    a_hi    = {{17{a[32]}}, a[32:16]};
    b_lo    = {18'b0, b[15:0]};
    b_hi    = {{17{b[32]}}, b[32:16]};
    pp_d.ll = a_lo * b_lo;
    pp_d.lh = a_lo * b_hi;
    pp_d.hl = a_hi * b_lo;
    pp_d.hh = a_hi * b_hi;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      pp <= '0;
    else if (en)
      pp <= pp_d;
  end

endmodule

// File: rtl/rv32_pipelined_mul_unit.sv
// Pipelined RV32M multiply unit with valid/ready, stall and flush.
// RV32_MUL_FXMADD_EN adds the scaled fixed-point multiply-add path.
module rv32_pipelined_mul_unit
  import rv32_types::*;
#(
  parameter int STAGES = MUL_UNIT_STAGES,
  parameter int TAG_W  = 5
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush,
  rv32_pipelined_mul_unit_if.slave    bus,
  input  logic                        scale_we,
  input  logic [2:0]                  scale_idx,
  input  fx_scale_t                   scale_val,
  output logic                        busy
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic              acc;
  logic [32:0]       a_q, b_q;
  ctl_t              ctl_q [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  ctl_t              ctl_d;
  logic              sgn1, sgn2;
  pp_t               pp1, pp_last;
  logic [65:0]       p;
  logic signed [65:0] ps;
  logic [31:0]       res;
  ctl_t              c;
  logic              unused_bits;

  // A stage moves when empty or when everything after it moves
  always_comb begin
    adv = '0;
    acc = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc    = acc | ~v[i];
      adv[i] = acc;
    end
  end

`ifdef RV32_MUL_FXMADD_EN
  fx_scale_t scale_q [FX_SCALE_ENTRIES];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < FX_SCALE_ENTRIES; i++)
        scale_q[i] <= '0;
    end else if (scale_we) begin
      scale_q[scale_idx] <= scale_val;
    end
  end

  always_comb begin
    ctl_d.op  = bus.in_op;
    ctl_d.fx  = bus.in_fx;
    ctl_d.sh  = scale_q[bus.in_scale];
    ctl_d.add = bus.in_add;
    sgn1 = bus.in_fx | (bus.in_op == MULH) | (bus.in_op == MULHSU);
    sgn2 = bus.in_fx | (bus.in_op == MULH);
  end
`else
  logic unused_fx;
  assign unused_fx = ^{bus.in_fx, bus.in_scale, bus.in_add,
                       scale_we, scale_idx, scale_val};

  always_comb begin
    ctl_d.op  = bus.in_op;
    ctl_d.fx  = 1'b0;
    ctl_d.sh  = '0;
    ctl_d.add = '0;
    sgn1 = (bus.in_op == MULH) | (bus.in_op == MULHSU);
    sgn2 = (bus.in_op == MULH);
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      v <= '0;
    end else begin
      if (adv[0])
        v[0] <= bus.in_valid;
      for (int i = 1; i < STAGES; i++)
        if (adv[i])
          v[i] <= v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        ctl_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        a_q      <= {sgn1 & bus.in_op1[31], bus.in_op1};
        b_q      <= {sgn2 & bus.in_op2[31], bus.in_op2};
        ctl_q[0] <= ctl_d;
        tag_q[0] <= bus.in_tag;
      end
      for (int i = 1; i < STAGES; i++)
        if (adv[i]) begin
          ctl_q[i] <= ctl_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
    end
  end

  rv32_mul_pp_stage u_pp (
    .clk    (clk),
    .resetn (resetn),
    .en     (adv[1]),
    .a      (a_q),
    .b      (b_q),
    .pp     (pp1)
  );

  generate
    if (STAGES > 2) begin : g_dly
      pp_t dly [STAGES-2];
      always_ff @(posedge clk) begin
        if (!resetn) begin
          for (int j = 0; j < STAGES - 2; j++)
            dly[j] <= '0;
        end else begin
          if (adv[2])
            dly[0] <= pp1;
          for (int j = 1; j < STAGES - 2; j++)
            if (adv[j+2])
              dly[j] <= dly[j-1];
        end
      end
      assign pp_last = dly[STAGES-3];
    end else begin : g_nodly
      assign pp_last = pp1;
    end
  endgenerate

  always_comb begin
    c   = ctl_q[STAGES-1];
    p   = pp_sum(pp_last);
    ps  = $signed(p) >>> c.sh;
    res = (c.op == MUL) ? p[31:0] : p[63:32];
    if (c.fx)
      res = c.add + ps[31:0];
  end

  assign unused_bits    = ^{p[65:64], ps[65:32]};
  assign bus.in_ready   = adv[0];
  assign bus.out_valid  = v[STAGES-1];
  assign bus.out_result = res;
  assign bus.out_tag    = tag_q[STAGES-1];
  assign busy           = |v;

endmodule
